mul_unit: RTL and testbench

//  Multi-cycle radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.

---
 rtl/mul_unit.sv | 114 +++++++++++
 tb/tb_mul_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Sign-magnitude core: operates on |rs1|,|rs2| and re-applies the sign in FIX.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] mul_output,
  output logic [XLEN-1:0]   result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q,   acc_d;
  logic                neg_q,   neg_d;
  logic [1:0]          op_q,    op_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [2*XLEN-1:0]   prod_q,  prod_d;
  logic [XLEN-1:0]     res_q,   res_d;
  logic                done_q,  done_d;

  logic                sgn1, sgn2;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       sum;

  // Magnitudes stay unsigned XLEN bits, so -2^(XLEN-1) maps cleanly to 2^(XLEN-1).
  assign sgn1 = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[XLEN-1];
  assign sgn2 = (op == OP_MULH) && rs2[XLEN-1];
  assign mag1 = sgn1 ? (~rs1 + 1'b1) : rs1;
  assign mag2 = sgn2 ? (~rs2 + 1'b1) : rs2;

  // acc = {partial high, remaining multiplier}; the add keeps its carry for the shift.
  assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mag1;
          acc_d   = {{XLEN{1'b0}}, mag2};
          neg_d   = sgn1 ^ sgn2;
          op_d    = op;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = {sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        prod_d  = neg_q ? (~acc_q + 1'b1) : acc_q;
        res_d   = (op_q == OP_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == S_CALC) || (state_q == S_FIX);
  assign done       = done_q;
  assign mul_output = prod_q;
  assign result     = res_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner ops, start-while-busy,
// mid-op reset, then randomized ops against a plain-arithmetic product model.
module tb_mul_unit;
  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic        busy, done;
  logic [63:0] mul_output;
  logic [31:0] result;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last_prod = '0;
  logic [31:0] last_res  = '0;

  mul_unit #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
    .mul_output(mul_output), .result(result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full 64-bit product: extend each operand per its signedness, multiply mod 2^64.
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse);
    logic [63:0] exp;
    logic [31:0] exp_res;
    int          cyc;
    bit          got;
    int          ndone;
    exp     = ref_mul(o, a, b);
    exp_res = (o == 2'b00) ? exp[31:0] : exp[63:32];
    @(negedge clock);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clock);
    #1;
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
    start = 1'b0;
    rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      @(posedge clock);
      cyc++;
      #1;
      if (done) got = 1'b1;
      else begin
        chk("busy_hold", {63'b0, busy}, 64'd1);
        chk("prod_hold", mul_output, last_prod);
        start = repulse && cyc >= 2 && cyc <= 9;
        rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
      end
    end
    start = 1'b0;
    chk("done_seen", {63'b0, got}, 64'd1);
    chk("latency", 64'(cyc), 64'(XLEN + 1));
    chk("busy_at_done", {63'b0, busy}, 64'd0);
    chk("mul_output", mul_output, exp);
    chk("result", {32'b0, result}, {32'b0, exp_res});
    last_prod = exp;
    last_res  = exp_res;
    @(posedge clock);
    #1;
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    if (repulse) begin
      ndone = 0;
      repeat (40) begin
        @(posedge clock);
        #1;
        if (done || busy) ndone++;
      end
      chk("no_extra_op", 64'(ndone), 64'd0);
      chk("prod_stable", mul_output, exp);
    end
  endtask

  initial begin
    int ndone;
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_prod", mul_output, 64'd0);
    chk("rst_res",  {32'b0, result}, 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'h0, 32'h1234_5678, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Abort mid-calculation; outputs must clear immediately.
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clock);
    op = 2'b01; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_prod", mul_output, 64'd0);
    chk("abort_res",  {32'b0, result}, 64'd0);
    last_prod = '0;
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);

    for (int i = 0; i < 80; i++)
      run_op(2'($urandom), pick(), pick(), ($urandom_range(0, 9) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
